// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed four-digit 7-segment scanner for the Nexys4 DDR display.
// Digits are committed only at frame boundaries, and each slot opens with an anti-ghosting gap.
module bcd_seg7_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYCLES  = 1000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [3:0] Thousands,
    input  logic [3:0] Hundreds,
    input  logic [3:0] Tens,
    input  logic [3:0] Ones,
    input  logic       bcd_valid,
    input  logic [3:0] dp_mask,
    input  logic       lz_blank,
    output logic [7:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       frame_tick
);

    localparam int              CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYCLES);

    logic [CNT_W-1:0] tick_cnt;
    logic [1:0]       digit_idx;

    logic [3:0][3:0]  pend_digits;
    logic [3:0]       pend_dp;
    logic             pending_valid;
    logic [3:0][3:0]  disp_digits;
    logic [3:0]       disp_dp;

    logic             slot_end;
    logic             frame_boundary;
    logic [3:0][3:0]  in_digits;

    assign slot_end       = (tick_cnt == TICK_LAST);
    assign frame_boundary = slot_end && (digit_idx == 2'd3);
    assign in_digits      = {Thousands, Hundreds, Tens, Ones};

    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = 7'h3F;
        endcase
        return pattern;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            tick_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_end) begin
            tick_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            tick_cnt  <= tick_cnt + 1'b1;
        end
    end

    // A strobe landing on the boundary bypasses pending so it is not held back a whole frame.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pend_digits   <= '0;
            pend_dp       <= '0;
            pending_valid <= 1'b0;
            disp_digits   <= '0;
            disp_dp       <= '0;
        end else begin
            if (bcd_valid) begin
                pend_digits <= in_digits;
                pend_dp     <= dp_mask;
            end
            if (frame_boundary) begin
                pending_valid <= 1'b0;
                if (bcd_valid) begin
                    disp_digits <= in_digits;
                    disp_dp     <= dp_mask;
                end else if (pending_valid) begin
                    disp_digits <= pend_digits;
                    disp_dp     <= pend_dp;
                end
            end else if (bcd_valid) begin
                pending_valid <= 1'b1;
            end
        end
    end

    logic [3:0] blank;
    logic [7:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    // Blanking ripples down from the leftmost digit; a lit decimal point breaks the chain.
    always_comb begin
        blank    = '0;
        blank[3] = lz_blank && (disp_digits[3] == 4'd0) && !disp_dp[3];
        blank[2] = blank[3] && (disp_digits[2] == 4'd0) && !disp_dp[2];
        blank[1] = blank[2] && (disp_digits[1] == 4'd0) && !disp_dp[1];
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        an_next  = 8'hFF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if ((tick_cnt >= GAP_END) && !blank[digit_idx]) begin
            an_next[digit_idx] = 1'b0;
            seg_next           = decode(disp_digits[digit_idx]);
            dp_next            = ~disp_dp[digit_idx];
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            AN         <= 8'hFF;
            SEG        <= 7'h7F;
            DP         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            AN         <= an_next;
            SEG        <= seg_next;
            DP         <= dp_next;
            frame_tick <= frame_boundary;
        end
    end

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Directed bench for bcd_seg7_scanner with a short slot (8 cycles, 2 gap cycles).
// Outputs are sampled on the falling edge; one frame spans 32 cycles.
module tb_bcd_seg7_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] thousands = '0, hundreds = '0, tens = '0, ones = '0;
    logic       bcd_valid = 1'b0;
    logic [3:0] dp_mask = '0;
    logic       lz_blank = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [7:0] cap_an[4];
    logic [6:0] cap_seg[4];
    logic       cap_dp[4];

    bcd_seg7_scanner #(.REFRESH_DIV(8), .GAP_CYCLES(2)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .Thousands (thousands),
        .Hundreds  (hundreds),
        .Tens      (tens),
        .Ones      (ones),
        .bcd_valid (bcd_valid),
        .dp_mask   (dp_mask),
        .lz_blank  (lz_blank),
        .AN        (an),
        .SEG       (seg),
        .DP        (dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) check("frame_tick_timeout", 32'd0, 32'd1);
    endtask

    // Call on the falling edge where frame_tick is high; samples each digit mid-slot.
    task automatic capture_frame(input string tag);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (n == 1) check({tag, "_gap_an"}, an, 8'hFF);
            if ((n - 1) % 8 == 4) begin
                cap_an[(n - 1) / 8]  = an;
                cap_seg[(n - 1) / 8] = seg;
                cap_dp[(n - 1) / 8]  = dp;
            end
        end
    endtask

    task automatic expect_digit(input string tag, input int d, input logic [7:0] e_an,
                                input logic [6:0] e_seg, input logic e_dp);
        check($sformatf("%s_d%0d_an", tag, d), cap_an[d], e_an);
        check($sformatf("%s_d%0d_seg", tag, d), cap_seg[d], e_seg);
        check($sformatf("%s_d%0d_dp", tag, d), cap_dp[d], e_dp);
    endtask

    task automatic load(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te,
                        input logic [3:0] on, input logic [3:0] dpm);
        thousands = th; hundreds = hu; tens = te; ones = on; dp_mask = dpm;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
    endtask

    // Call right after reset release on a falling edge.
    task automatic reset_scan(input string tag);
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            case (n)
                1, 2: check($sformatf("%s_gap%0d_an", tag, n), an, 8'hFF);
                3: begin
                    check({tag, "_d0_an"}, an, 8'hFE);
                    check({tag, "_d0_seg"}, seg, 7'h40);
                    check({tag, "_d0_dp"}, dp, 1'b1);
                end
                8:  check({tag, "_d0_last_an"}, an, 8'hFE);
                9:  check({tag, "_d1_gap_an"}, an, 8'hFF);
                11: begin
                    check({tag, "_d1_an"}, an, 8'hFD);
                    check({tag, "_d1_seg"}, seg, 7'h40);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_ft", frame_tick, 1'b0);
        rst_n = 1'b1;
        reset_scan("init");

        // Commit timing: mid-frame strobe must not show until the next boundary.
        wait_frame();
        repeat (10) @(negedge clk);
        load(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
        repeat (18) @(negedge clk);
        check("commit_old_d3_an", an, 8'hF7);
        check("commit_old_d3_seg", seg, 7'h40);
        wait_frame();
        capture_frame("commit");
        expect_digit("commit", 3, 8'hF7, 7'h79, 1'b1);
        expect_digit("commit", 2, 8'hFB, 7'h24, 1'b1);
        expect_digit("commit", 1, 8'hFD, 7'h30, 1'b1);
        expect_digit("commit", 0, 8'hFE, 7'h19, 1'b1);

        load(4'd6, 4'd7, 4'd8, 4'd9, 4'b0000);
        wait_frame();
        capture_frame("dec");
        expect_digit("dec", 3, 8'hF7, 7'h02, 1'b1);
        expect_digit("dec", 2, 8'hFB, 7'h78, 1'b1);
        expect_digit("dec", 1, 8'hFD, 7'h00, 1'b1);
        expect_digit("dec", 0, 8'hFE, 7'h10, 1'b1);

        lz_blank = 1'b1;
        load(4'd0, 4'd0, 4'd4, 4'd2, 4'b0000);
        wait_frame();
        capture_frame("lz");
        expect_digit("lz", 3, 8'hFF, 7'h7F, 1'b1);
        expect_digit("lz", 2, 8'hFF, 7'h7F, 1'b1);
        expect_digit("lz", 1, 8'hFD, 7'h19, 1'b1);
        expect_digit("lz", 0, 8'hFE, 7'h24, 1'b1);

        lz_blank = 1'b0;
        wait_frame();
        capture_frame("nolz");
        expect_digit("nolz", 3, 8'hF7, 7'h40, 1'b1);
        expect_digit("nolz", 2, 8'hFB, 7'h40, 1'b1);

        lz_blank = 1'b1;
        load(4'd0, 4'd0, 4'd0, 4'd5, 4'b0010);
        wait_frame();
        capture_frame("dpov");
        expect_digit("dpov", 3, 8'hFF, 7'h7F, 1'b1);
        expect_digit("dpov", 2, 8'hFF, 7'h7F, 1'b1);
        expect_digit("dpov", 1, 8'hFD, 7'h40, 1'b0);
        expect_digit("dpov", 0, 8'hFE, 7'h12, 1'b1);

        // Collision: a pending value exists, then a strobe lands on the boundary cycle.
        lz_blank = 1'b0;
        wait_frame();
        repeat (10) @(negedge clk);
        load(4'd9, 4'd9, 4'd9, 4'd9, 4'b0000);
        check("coll_pend_set", dut.pending_valid, 1'b1);
        repeat (20) @(negedge clk);
        thousands = 4'd1; hundreds = 4'd2; tens = 4'hC; ones = 4'd3; dp_mask = 4'b0000;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        check("coll_ft", frame_tick, 1'b1);
        check("coll_pend_clr", dut.pending_valid, 1'b0);
        capture_frame("coll");
        expect_digit("coll", 3, 8'hF7, 7'h79, 1'b1);
        expect_digit("coll", 2, 8'hFB, 7'h24, 1'b1);
        expect_digit("coll", 1, 8'hFD, 7'h3F, 1'b1);
        expect_digit("coll", 0, 8'hFE, 7'h30, 1'b1);
        check("coll_pend_after", dut.pending_valid, 1'b0);

        // Asynchronous reset in the middle of digit 1's active phase.
        repeat (12) @(negedge clk);
        check("arst_pre_an", an, 8'hFD);
        check("arst_pre_seg", seg, 7'h3F);
        #1 rst_n = 1'b0;
        #1;
        check("arst_an", an, 8'hFF);
        check("arst_seg", seg, 7'h7F);
        check("arst_dp", dp, 1'b1);
        check("arst_ft", frame_tick, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reset_scan("arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bcd_seg7_scanner.md
Name: bcd_seg7_scanner

Overview:
- Time-multiplexed 7-segment driver for the Nexys4 DDR display.
- Sits directly downstream of the binary-to-BCD converter and consumes its four BCD digits (Thousands/Hundreds/Tens/Ones).
- Scans the four digits onto AN[3:0] with anti-ghosting gaps, leading-zero blanking and decimal-point control. AN[7:4] are held off.
- New values are committed only at frame boundaries, so a displayed frame never tears.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz/digit at 100 MHz); must be >= 2
GAP_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV

Ports:
CLK100MHZ  in  1  system clock, all logic on the rising edge
CPU_RESETN  in  1  asynchronous active-low reset
Thousands  in  4  BCD digit 3 (leftmost)
Hundreds  in  4  BCD digit 2
Tens  in  4  BCD digit 1
Ones  in  4  BCD digit 0 (rightmost)
bcd_valid  in  1  capture strobe for the four digits plus dp_mask
dp_mask  in  4  decimal-point enable per digit, bit i = digit i
lz_blank  in  1  1 = enable leading-zero blanking (live, not latched)
AN  out  8  anodes, active-low
SEG  out  7  cathodes {CG,CF,CE,CD,CC,CB,CA}, active-low
DP  out  1  decimal point, active-low
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset is asynchronous on CPU_RESETN=0. It clears tick_cnt, digit_idx, the pending and display registers and pending_valid. Outputs at reset: AN=8'hFF, SEG=7'h7F, DP=1, frame_tick=0. Reset mid-frame aborts the scan; after release, scanning restarts at digit 0 in its gap.
- tick_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
- On wrap, digit_idx advances 0->1->2->3->0.
- Frame boundary: the cycle where tick_cnt=REFRESH_DIV-1 and digit_idx=3.
- Capture: when bcd_valid=1, the digits and dp_mask are loaded into the pending registers and pending_valid is set. Back-to-back strobes overwrite, so the last value wins.
- Commit: at a frame boundary with pending_valid=1, pending is copied to display and pending_valid is cleared. frame_tick pulses at every frame boundary, committed or not.
- Simultaneous bcd_valid and frame boundary: the input values bypass straight into display, and pending_valid ends at 0.
- Outputs are registered. AN/SEG/DP at cycle n+1 reflect tick_cnt/digit_idx/display at cycle n, and frame_tick has the same 1-cycle lag.
- Gap phase (tick_cnt < GAP_CYCLES): AN=8'hFF, SEG=7'h7F, DP=1.
- Active phase, for digit d=digit_idx:
  - If d is not blanked: AN[d]=0 and all other AN bits are 1. SEG=decode(display[d]). DP=~display_dp[d].
  - If d is blanked: AN=8'hFF, SEG=7'h7F, DP=1.
- Blanking, when lz_blank=1:
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if digits 3 and 2 are both blanked/0; digit 1 likewise, requiring 3, 2 and 1.
  - Digit 0 is never blanked.
  - A set dp bit on digit k stops blanking for digit k and every lower digit.
  - When lz_blank=0, no digit is blanked.
- Decode (SEG hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - 10..15 show a dash: 3F.
- AN[7:4] are always 1.

Test Plan:
- Reset (REFRESH_DIV=8, GAP_CYCLES=2): hold CPU_RESETN=0 -> AN=FF, SEG=7F, DP=1. Release -> AN stays FF for the 2 gap cycles, then AN=FE with SEG=40 (digits 0) for 6 cycles, then AN=FD after 2 gap cycles.
- Commit timing: pulse bcd_valid with 1,2,3,4 mid-frame -> display stays 0000 until frame_tick. The next frame shows AN=F7/SEG=79, FB/24, FD/30, FE/19.
- Blanking: load 0,0,4,2 with lz_blank=1 -> digits 3 and 2 keep AN=FF; digit 1 shows SEG=19, digit 0 shows SEG=24. With lz_blank=0 -> digits 3 and 2 show SEG=40.
- DP override: load 0,0,0,5 with dp_mask=0010, lz_blank=1 -> digits 3 and 2 blanked. Digit 1 shows SEG=40 with DP=0; digit 0 shows SEG=12 with DP=1.
- Invalid BCD and collision: load Tens=4'hC with bcd_valid on the frame-boundary cycle -> committed immediately. Next frame digit 1 shows SEG=3F, pending_valid=0.
- Async reset during an active phase: assert CPU_RESETN=0 mid-clock -> AN=FF without waiting for a clock edge. Display is cleared, and the scan restarts at digit 0.
